// File: rtl/mul_pkg.sv
// Shared types and sizes for the sequential shift-add multiplier.
package mul_pkg;

  localparam int MUL_WIDTH  = 8;
  localparam int MUL_PWIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_seq_cla.sv
// 16-bit carry-lookahead adder: 4-bit groups with a second-level group carry chain.
module mul_seq_cla (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        C_in,
  output logic [15:0] S,
  output logic        Ovfl
);

  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;
  logic [16:0] c;

  always_comb begin
    g  = A & B;
    p  = A ^ B;
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    gc[0] = C_in;
    for (int k = 0; k < 4; k++) begin
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
    // Bit carries within a group start from the lookahead group carry.
    for (int k = 0; k < 4; k++) begin
      c[4*k] = gc[k];
      for (int i = 0; i < 3; i++) begin
        c[4*k+i+1] = g[4*k+i] | (p[4*k+i] & c[4*k+i]);
      end
    end
    c[16] = gc[4];
    S     = p ^ c[15:0];
    Ovfl  = c[15] ^ c[16];
  end

endmodule

// File: rtl/mul_seq.sv
// Iterative unsigned multiplier: one shift-add step per cycle through the shared 16-bit CLA.
module mul_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output state_t             state
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] sum;

  // The adder is fixed at 16 bits, so only WIDTH=8 fits it.
  mul_seq_cla u_cla (
    .A    (acc),
    .B    (mcand),
    .C_in (1'b0),
    .S    (sum),
    .Ovfl ()
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            cnt    <= '0;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          if (mplier[0]) acc <= sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          // Fixed-length run; no early exit when the multiplier empties.
          if (cnt == CW'(WIDTH - 1)) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy    = (state == RUN);
  assign done    = (state == DONE);
  assign product = acc;

endmodule
